mc_control_unit: RTL and testbench
==================================

# mc_control_unit

Multicycle control unit that drives the ALU's `ALUControl` port and the rest of the RV32I subset datapath (lw, sw, R-type, I-type ALU, beq, jal). It replaces the single-cycle combinational control when the core moves to a shared-memory multicycle datapath. It is a Moore FSM plus a combinational ALU decoder. It consumes the ALU `Zero` flag for branch resolution.

## Interface
Parameters:
- none; opcode and encoding constants come from `riscv_pkg`.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `op`  in  7  instruction opcode, Instr[6:0], from the instruction register.
- `funct3`  in  3  Instr[14:12].
- `funct7b5`  in  1  Instr[30].
- `Zero`  in  1  ALU zero flag, combinational from the current ALU result.
- `PCWrite`  out  1  PC register enable.
- `AdrSrc`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `MemWrite`  out  1  data memory write enable.
- `IRWrite`  out  1  instruction register / OldPC enable.
- `RegWrite`  out  1  register file write enable.
- `ResultSrc`  out  2  result mux select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- `ALUSrcA`  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = RD1.
- `ALUSrcB`  out  2  ALU B select: 00 = RD2, 01 = ImmExt, 10 = constant 4.
- `ImmSrc`  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J.
- `ALUControl`  out  3  ALU operation: 000 = add, 001 = sub, 010 = and, 011 = or, 101 = slt.
- `illegal_instr`  out  1  one-cycle pulse in DECODE when `op` is unsupported.

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL.
- **FETCH**
  - AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1.
  - Next state: DECODE.
- **DECODE**
  - ALUSrcA=01, ALUSrcB=01, ALUOp=00 (computes the branch target).
  - Next state by `op`: 0000011 or 0100011 → MEMADR; 0110011 → EXECUTER; 0010011 → EXECUTEI; 1100011 → BEQ; 1101111 → JAL; anything else → FETCH with `illegal_instr`=1.
- **MEMADR**: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Next: MEMREAD if op=lw, else MEMWRITE.
- **MEMREAD**: ResultSrc=00, AdrSrc=1. Next: MEMWB.
- **MEMWB**: ResultSrc=01, RegWrite=1. Next: FETCH.
- **MEMWRITE**: ResultSrc=00, AdrSrc=1, MemWrite=1. Next: FETCH.
- **EXECUTER**: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Next: ALUWB.
- **EXECUTEI**: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Next: ALUWB.
- **ALUWB**: ResultSrc=00, RegWrite=1. Next: FETCH.
- **BEQ**: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1. Next: FETCH.
- **JAL**: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1. Next: ALUWB.
- Defaults: every output not listed for a state is 0 (`ALUControl` follows the decoder).
- PCWrite = PCUpdate | (Branch & Zero).
- ImmSrc is decoded from `op` in every state: lw/I-type → 00, sw → 01, beq → 10, jal → 11, other → 00.
- ALU decoder:
  - ALUOp=00 → 000 (add); ALUOp=01 → 001 (sub).
  - ALUOp=10, by funct3:
    - 000 → 001 if (op[5] & funct7b5), else 000.
    - 010 → 101 (slt).
    - 110 → 011 (or).
    - 111 → 010 (and).
    - other → 000.
- The ALU decoder generates no encodings other than 000, 001, 010, 011 and 101.

## Timing
- Outputs are combinational from the state register plus `op`/`funct3`/`funct7b5`/`Zero`. No registered outputs.
- Cycles per instruction, FETCH through last state: lw 5, sw 4, R 4, I 4, jal 4, beq 3, illegal 2.
- `rst`=1 forces the state to FETCH asynchronously.
- While `rst`=1, PCWrite, IRWrite, MemWrite, RegWrite and `illegal_instr` are forced to 0. All other outputs take their FETCH values.
- After `rst` deasserts, the first rising edge executes FETCH.
- Reset mid-instruction abandons the instruction; no partial write completes once `rst` is high.
- `Zero` is sampled only in BEQ. A change in `Zero` during any other state has no effect.
- `op` must stay stable from DECODE to the end of the instruction (the IR is written only in FETCH).

## Structure
- Package `riscv_pkg` holds:
  - opcode constants (OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL);
  - ALUControl encodings (ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT);
  - the ALUOp encodings;
  - the state enum type.
- Sub-module `alu_decoder`: inputs ALUOp, funct3, op[5], funct7b5; output ALUControl. The same sub-module is reused by the single-cycle control.
- The top-level FSM holds the state register, next-state logic, output decode and the ImmSrc decode.

## Test plan
- Reset asserted mid-MEMWRITE of sw → MemWrite drops to 0 the same cycle; state is FETCH; IRWrite=1 on the first edge after release.
- lw (op=0000011) → state sequence FETCH, DECODE, MEMADR, MEMREAD, MEMWB (5 cycles); RegWrite=1 only in MEMWB with ResultSrc=01; ALUControl=000 in MEMADR.
- R-type sub (funct3=000, funct7b5=1) → ALUControl=001 in EXECUTER. Same fields with op=0010011 (addi) → 000. funct3=010 → 101, 110 → 011, 111 → 010.
- beq with Zero=1 in BEQ → PCWrite=1, ALUControl=001. Repeat with Zero=0 → PCWrite=0. Zero=1 held during EXECUTER of an R-type → PCWrite=0.
- jal → FETCH, DECODE, JAL, ALUWB; PCWrite=1 in FETCH and JAL; ImmSrc=11; RegWrite=1 in ALUWB.
- op=1111111 → FETCH, DECODE with illegal_instr=1 for exactly one cycle, then FETCH; no write enable asserted.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I-subset encodings: opcodes, ALU operation codes, ALUOp classes
// and the multicycle control FSM state type.
package riscv_pkg;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECUTER, EXECUTEI, ALUWB, BEQ, JAL
  } state_t;

endpackage

// File: rtl/alu_decoder.sv
// Maps ALUOp plus instruction fields to an ALUControl code; shared with the
// single-cycle control path.
module alu_decoder
  import riscv_pkg::*;
(
  input  aluop_t     ALUOp,
  input  logic [2:0] funct3,
  input  logic       op5,
  input  logic       funct7b5,
  output logic [2:0] ALUControl
);

  always_comb begin
    ALUControl = ALU_ADD;
    case (ALUOp)
      ALUOP_ADD: ALUControl = ALU_ADD;
      ALUOP_SUB: ALUControl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // sub only for R-type with Instr[30] set; addi ignores funct7
          3'b000:  ALUControl = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  ALUControl = ALU_SLT;
          3'b110:  ALUControl = ALU_OR;
          3'b111:  ALUControl = ALU_AND;
          default: ALUControl = ALU_ADD;
        endcase
      end
      default: ALUControl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle RV32I-subset control: Moore FSM driving datapath selects and
// enables, with ImmSrc decode and an ALU decoder sub-block.
module mc_control_unit
  import riscv_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       illegal_instr
);

  state_t state, state_next;
  aluop_t alu_op;
  logic   pc_update, branch, mem_write, ir_write, reg_write, illegal;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FETCH;
    else     state <= state_next;
  end

  always_comb begin
    state_next = FETCH;
    alu_op     = ALUOP_ADD;
    pc_update  = 1'b0;
    branch     = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    illegal    = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    case (state)
      FETCH: begin
        ir_write   = 1'b1;
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
        pc_update  = 1'b1;
        state_next = DECODE;
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LW, OP_SW: state_next = MEMADR;
          OP_R:         state_next = EXECUTER;
          OP_I:         state_next = EXECUTEI;
          OP_BEQ:       state_next = BEQ;
          OP_JAL:       state_next = JAL;
          default: begin
            state_next = FETCH;
            illegal    = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        state_next = (op == OP_LW) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        AdrSrc     = 1'b1;
        state_next = MEMWB;
      end
      MEMWB: begin
        ResultSrc  = 2'b01;
        reg_write  = 1'b1;
        state_next = FETCH;
      end
      MEMWRITE: begin
        AdrSrc     = 1'b1;
        mem_write  = 1'b1;
        state_next = FETCH;
      end
      EXECUTER: begin
        ALUSrcA    = 2'b10;
        alu_op     = ALUOP_FUNCT;
        state_next = ALUWB;
      end
      EXECUTEI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        alu_op     = ALUOP_FUNCT;
        state_next = ALUWB;
      end
      ALUWB: begin
        reg_write  = 1'b1;
        state_next = FETCH;
      end
      BEQ: begin
        ALUSrcA    = 2'b10;
        alu_op     = ALUOP_SUB;
        branch     = 1'b1;
        state_next = FETCH;
      end
      JAL: begin
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b10;
        pc_update  = 1'b1;
        state_next = ALUWB;
      end
      default: state_next = FETCH;
    endcase
  end

  always_comb begin
    case (op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BEQ:  ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  // Enables are gated by rst so an abandoned instruction cannot write while reset is held.
  assign PCWrite       = ~rst & (pc_update | (branch & Zero));
  assign MemWrite      = ~rst & mem_write;
  assign IRWrite       = ~rst & ir_write;
  assign RegWrite      = ~rst & reg_write;
  assign illegal_instr = ~rst & illegal;

  alu_decoder u_alu_decoder (
    .ALUOp      (alu_op),
    .funct3     (funct3),
    .op5        (op[5]),
    .funct7b5   (funct7b5),
    .ALUControl (ALUControl)
  );

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit: walks each instruction class through
// the FSM and compares the full output bundle against hand-derived vectors.
module tb_mc_control_unit;
  import riscv_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] op = OP_LW;
  logic [2:0] funct3 = 3'b000;
  logic       funct7b5 = 1'b0;
  logic       Zero = 1'b0;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal_instr;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic [16:0] outs;

  int unsigned errors = 0;
  int unsigned checks = 0;

  mc_control_unit dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
    .ALUControl(ALUControl), .illegal_instr(illegal_instr)
  );

  always #5 clk = ~clk;

  assign outs = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                 ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal_instr};

  function automatic logic [16:0] ev(input logic pcw, input logic adr,
      input logic mw, input logic irw, input logic rw, input logic [1:0] rs,
      input logic [1:0] sa, input logic [1:0] sb, input logic [1:0] imm,
      input logic [2:0] alu, input logic ill);
    return {pcw, adr, mw, irw, rw, rs, sa, sb, imm, alu, ill};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input state_t exp_s, input logic [16:0] exp_o);
    chk({tag, "_state"}, 32'(dut.state), 32'(exp_s));
    chk({tag, "_outs"}, 32'(outs), 32'(exp_o));
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset held: FETCH selects, enables forced low
    #2;
    chk_state("rst_hold", FETCH, ev(0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,3'b000,0));
    rst = 1'b0;
    #1;
    chk_state("lw_fetch", FETCH, ev(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0));
    step; chk_state("lw_decode", DECODE,  ev(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0));
    step; chk_state("lw_memadr", MEMADR,  ev(0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b000,0));
    step; chk_state("lw_memread", MEMREAD, ev(0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0));
    step; chk_state("lw_memwb", MEMWB,   ev(0,0,0,0,1,2'b01,2'b00,2'b00,2'b00,3'b000,0));
    step;
    op = OP_SW;
    #1;
    chk_state("sw_fetch", FETCH, ev(1,0,0,1,0,2'b10,2'b00,2'b10,2'b01,3'b000,0));
    step; chk_state("sw_decode", DECODE, ev(0,0,0,0,0,2'b00,2'b01,2'b01,2'b01,3'b000,0));
    step; chk_state("sw_memadr", MEMADR, ev(0,0,0,0,0,2'b00,2'b10,2'b01,2'b01,3'b000,0));
    step; chk_state("sw_memwrite", MEMWRITE, ev(0,1,1,0,0,2'b00,2'b00,2'b00,2'b01,3'b000,0));
    // asynchronous reset mid-MEMWRITE
    rst = 1'b1;
    #1;
    chk("sw_rst_memwrite", 32'(MemWrite), 32'd0);
    chk_state("sw_rst", FETCH, ev(0,0,0,0,0,2'b10,2'b00,2'b10,2'b01,3'b000,0));
    rst = 1'b0;
    op = OP_R; funct3 = 3'b000; funct7b5 = 1'b1; Zero = 1'b1;
    #1;
    chk("post_rst_irwrite", 32'(IRWrite), 32'd1);
    step; chk_state("r_decode", DECODE, ev(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0));
    step; chk_state("r_sub", EXECUTER, ev(0,0,0,0,0,2'b00,2'b10,2'b00,2'b00,3'b001,0));
    chk("r_zero_no_pcw", 32'(PCWrite), 32'd0);
    funct3 = 3'b010; #1; chk("r_slt", 32'(ALUControl), 32'(ALU_SLT));
    funct3 = 3'b110; #1; chk("r_or",  32'(ALUControl), 32'(ALU_OR));
    funct3 = 3'b111; #1; chk("r_and", 32'(ALUControl), 32'(ALU_AND));
    funct3 = 3'b001; #1; chk("r_f3_other", 32'(ALUControl), 32'(ALU_ADD));
    funct3 = 3'b000; funct7b5 = 1'b0; #1; chk("r_add", 32'(ALUControl), 32'(ALU_ADD));
    step; chk_state("r_aluwb", ALUWB, ev(0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,3'b000,0));
    step;
    op = OP_I; funct7b5 = 1'b1; Zero = 1'b0;
    #1;
    chk_state("i_fetch", FETCH, ev(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0));
    step; step;
    chk_state("i_addi", EXECUTEI, ev(0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b000,0));
    step; chk_state("i_aluwb", ALUWB, ev(0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,3'b000,0));
    step;
    op = OP_BEQ; Zero = 1'b1;
    step; chk_state("beq_decode", DECODE, ev(0,0,0,0,0,2'b00,2'b01,2'b01,2'b10,3'b000,0));
    step; chk_state("beq_taken", BEQ, ev(1,0,0,0,0,2'b00,2'b10,2'b00,2'b10,3'b001,0));
    Zero = 1'b0;
    #1;
    chk_state("beq_not_taken", BEQ, ev(0,0,0,0,0,2'b00,2'b10,2'b00,2'b10,3'b001,0));
    step;
    op = OP_JAL; Zero = 1'b1;
    #1;
    chk_state("jal_fetch", FETCH, ev(1,0,0,1,0,2'b10,2'b00,2'b10,2'b11,3'b000,0));
    step; chk_state("jal_decode", DECODE, ev(0,0,0,0,0,2'b00,2'b01,2'b01,2'b11,3'b000,0));
    step; chk_state("jal_jal", JAL, ev(1,0,0,0,0,2'b00,2'b01,2'b10,2'b11,3'b000,0));
    step; chk_state("jal_aluwb", ALUWB, ev(0,0,0,0,1,2'b00,2'b00,2'b00,2'b11,3'b000,0));
    step;
    op = 7'b1111111;
    step; chk_state("ill_decode", DECODE, ev(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,1));
    step; chk_state("ill_fetch", FETCH, ev(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
